gen_cache: RTL and testbench
============================

GEN_CACHE -- requirements
Module: gen_cache

Interface
REQ-001 Parameter NUM_SET, default 16, number of sets; power of 2, at least 2.
REQ-002 Parameter NUM_WAY, default 4, associativity; one of 1, 2, 4, 8.
REQ-003 Parameter WRITE_EN, default 1; 0 gives a read-only cache: wmask is ignored, there is no dirty state and no writeback.
REQ-004 Derived constants: line is 256 bits with 5 offset bits; SET_IDX = log2(NUM_SET); TAG_BITS = 27 - SET_IDX.
REQ-005 Clock and reset:
- clk  in  1  single clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-006 Upward (CPU-side) port:
- ufp_addr  in  32  byte address.
- ufp_rmask  in  4  read byte mask.
- ufp_wmask  in  4  write byte mask.
- ufp_wdata  in  32  write data.
- ufp_rdata  out  32  read data.
- ufp_resp  out  1  one-cycle completion pulse.
REQ-007 Downward (memory-side) port:
- dfp_addr  out  32  line-aligned address.
- dfp_read  out  1  line read request.
- dfp_write  out  1  line write request.
- dfp_rdata  in  256  line read data.
- dfp_wdata  out  256  line write data.
- dfp_resp  in  1  memory completion.
REQ-008 Control port:
- flush_all  in  1  write back and invalidate every line.
- flush_done  out  1  one-cycle pulse when the flush completes.
- squash  in  1  suppress the response of the in-flight request.

Function
REQ-009 Storage is per way: valid bits, dirty bits, tags, and 256-bit data, all in flop arrays with combinational read; each set holds NUM_WAY-1 tree-PLRU bits.
REQ-010 FSM states: IDLE, TAG, WB, ALLOC, FSCAN, FWB.
REQ-011 IDLE transitions:
- flush_all=1 -> FSCAN; this has priority, and a simultaneous request is not accepted.
- Otherwise, rmask|wmask nonzero -> latch addr, masks and wdata, then go to TAG.
- A request with WRITE_EN=0 and rmask=0 is accepted and completes as a no-op ufp_resp.
REQ-012 TAG hit condition: valid and tag match in exactly one way.
- Read hit: ufp_rdata = selected 32-bit word (offset[4:2]).
- Write hit: only the bytes enabled by wmask are written at byte offset addr[4:2]*4; the line's dirty bit is set.
- Either hit: update PLRU, return to IDLE.
REQ-013 ufp_resp and ufp_rdata are registered: the pulse is asserted the cycle after the TAG hit for exactly one cycle, so hit latency is 2 cycles from acceptance. ufp_rdata holds its value until the next response.
REQ-014 TAG miss, victim selection:
- Victim is the lowest-index invalid way; otherwise the way selected by PLRU.
- Victim valid and dirty -> WB; otherwise -> ALLOC.
REQ-015 WB state:
- Outputs: dfp_write=1, dfp_addr = {victim tag, set, 5'b0}, dfp_wdata = victim line.
- Outputs are held until dfp_resp; then go to ALLOC.
REQ-016 ALLOC state:
- Outputs: dfp_read=1, dfp_addr = {addr[31:5], 5'b0}.
- On dfp_resp: write the line, set valid, clear dirty, write the tag, then go to TAG; the re-check hits.
REQ-017 dfp_read and dfp_write are never asserted together, and both are 0 in IDLE and TAG.
REQ-018 PLRU rule:
- Node bit 0 means the left subtree is LRU; the victim walk follows the bits.
- An access sets each node bit on its path to point away from the accessed way.
- With NUM_WAY=1 there are no bits and the victim is way 0.
REQ-019 squash:
- squash=1 in any non-IDLE cycle, or in the acceptance cycle, suppresses the pending ufp_resp.
- Fill, writeback and write-hit updates still complete.
- ufp_rdata is not updated.
REQ-020 Flush sequence:
- FSCAN walks (set, way) from (0,0) to (NUM_SET-1, NUM_WAY-1), one entry per cycle.
- Valid and dirty entry -> FWB, which writes it back as in WB and then returns to FSCAN at the next entry.
- Each visited entry is invalidated and its dirty bit cleared.
- After the last entry: all PLRU bits are cleared, flush_done pulses for 1 cycle, and the FSM returns to IDLE.
REQ-021 flush_all outside IDLE is ignored, and no ufp_resp is produced during a flush.

Reset
REQ-022 rst low immediately clears the following: state=IDLE; all valid, dirty and PLRU bits=0; ufp_resp=0; ufp_rdata=0; dfp_read=0; dfp_write=0; dfp_addr=0; dfp_wdata=0; flush_done=0.
REQ-023 Reset mid-transaction (WB, ALLOC or FWB) abandons the transaction with no response; tag and data contents after reset are don't-care.

Verification (NUM_SET=16, NUM_WAY=4, WRITE_EN=1)
REQ-024 Cold read miss:
- Stimulus: read 0x0000_1004; memory returns a line whose word1 is 0xDEADBEEF.
- Required: dfp_read with addr 0x0000_1000, then ufp_rdata=0xDEADBEEF.
- Repeating the read gives ufp_resp 2 cycles after acceptance, with no dfp activity.
REQ-025 Byte write hit:
- Stimulus: write 0x0000_1004 with wmask=4'b0010 and wdata=0x0000_AB00, then read the same address.
- Required: 0xDEADABEF.
REQ-026 Dirty eviction:
- Stimulus: write 0x0000_0000, then read 0x200, 0x400, 0x600 and 0x800 (all set 0).
- Required: the fifth access does dfp_write to 0x0000_0000 before dfp_read of 0x800.
REQ-027 Flush with two dirty lines:
- Required: exactly 2 dfp_write pulses and 1 flush_done pulse.
- A following read of either address misses.
REQ-028 Reset and squash:
- Asserting rst during ALLOC drops dfp_read in the same cycle, and a subsequent read of that address misses.
- Asserting squash during a read miss gives no ufp_resp, and the next read of that address hits.

Source files
------------

// File: rtl/gen_cache.sv
// Set-associative write-back cache: tree-PLRU replacement, 256-bit line fill and
// writeback on the memory port, and a full flush walk over every (set, way).
module gen_cache #(
  parameter int NUM_SET  = 16,
  parameter int NUM_WAY  = 4,
  parameter int WRITE_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ufp_addr,
  input  logic [3:0]   ufp_rmask,
  input  logic [3:0]   ufp_wmask,
  input  logic [31:0]  ufp_wdata,
  output logic [31:0]  ufp_rdata,
  output logic         ufp_resp,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  output logic         dfp_write,
  input  logic [255:0] dfp_rdata,
  output logic [255:0] dfp_wdata,
  input  logic         dfp_resp,
  input  logic         flush_all,
  output logic         flush_done,
  input  logic         squash
);
  localparam int SET_IDX  = $clog2(NUM_SET);
  localparam int TAG_BITS = 27 - SET_IDX;
  localparam int WAY_W    = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
  localparam int LEVELS   = $clog2(NUM_WAY);
  localparam int PLRU_W   = (NUM_WAY > 1) ? NUM_WAY - 1 : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] TAG   = 3'd1;
  localparam logic [2:0] WB    = 3'd2;
  localparam logic [2:0] ALLOC = 3'd3;
  localparam logic [2:0] FSCAN = 3'd4;
  localparam logic [2:0] FWB   = 3'd5;

  logic [2:0]          r_state, w_state_next;
  logic                r_valid [NUM_SET][NUM_WAY];
  logic                r_dirty [NUM_SET][NUM_WAY];
  logic [TAG_BITS-1:0] r_tag   [NUM_SET][NUM_WAY];
  logic [255:0]        r_data  [NUM_SET][NUM_WAY];
  logic [PLRU_W-1:0]   r_plru  [NUM_SET];

  logic [31:2]         r_addr;
  logic [3:0]          r_rmask, r_wmask;
  logic [31:0]         r_wdata;
  logic                r_squash;
  logic [WAY_W-1:0]    r_victim, r_fway;
  logic [SET_IDX-1:0]  r_fset;

  logic [SET_IDX-1:0]  w_set;
  logic [TAG_BITS-1:0] w_tag;
  logic [2:0]          w_word;
  logic [NUM_WAY-1:0]  w_hit_vec;
  logic                w_hit, w_squash, w_flush_last;
  logic [WAY_W-1:0]    w_hit_way, w_victim;
  logic [31:0]         w_hit_word;
  logic [255:0]        w_merged;
  logic                w_accept, w_resp_fire, w_wr_hit, w_plru_upd, w_victim_load, w_fill;
  logic                w_flush_start, w_flush_inval, w_flush_adv, w_flush_finish;
  logic                w_unused_ok;

  // Bit 0 at a node means the left subtree is LRU; walk toward the LRU side.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [WAY_W-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      way  = (way << 1) | WAY_W'(bits[node]);
      node = 2 * node + 1 + int'(bits[node]);
    end
    return way;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
    logic [PLRU_W-1:0] nb;
    logic b;
    int node;
    nb   = bits;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      b        = way[LEVELS-1-l];
      nb[node] = ~b;
      node     = 2 * node + 1 + int'(b);
    end
    return nb;
  endfunction

  assign w_set       = r_addr[5 +: SET_IDX];
  assign w_tag       = r_addr[31 -: TAG_BITS];
  assign w_word      = r_addr[4:2];
  assign w_squash    = r_squash | squash;
  assign w_unused_ok = ^ufp_addr[1:0];
  assign w_flush_last = (r_fset == SET_IDX'(NUM_SET - 1)) && (r_fway == WAY_W'(NUM_WAY - 1));

  generate
    for (genvar gi = 0; gi < NUM_WAY; gi++) begin : g_hit
      assign w_hit_vec[gi] = r_valid[w_set][gi] && (r_tag[w_set][gi] == w_tag);
    end
  endgenerate

  assign w_hit = $onehot(w_hit_vec);

  always_comb begin
    w_hit_way = '0;
    for (int i = 0; i < NUM_WAY; i++)
      if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
    w_victim = plru_victim(r_plru[w_set]);
    for (int i = NUM_WAY - 1; i >= 0; i--)
      if (!r_valid[w_set][i]) w_victim = WAY_W'(i);
  end

  assign w_hit_word = r_data[w_set][w_hit_way][int'(w_word)*32 +: 32];

  always_comb begin
    w_merged = r_data[w_set][w_hit_way];
    for (int b = 0; b < 4; b++)
      if (r_wmask[b]) w_merged[int'(w_word)*32 + b*8 +: 8] = r_wdata[b*8 +: 8];
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_resp_fire    = 1'b0;
    w_wr_hit       = 1'b0;
    w_plru_upd     = 1'b0;
    w_victim_load  = 1'b0;
    w_fill         = 1'b0;
    w_flush_start  = 1'b0;
    w_flush_inval  = 1'b0;
    w_flush_adv    = 1'b0;
    w_flush_finish = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush_all) begin
          w_flush_start = 1'b1;
          w_state_next  = FSCAN;
        end else if (|(ufp_rmask | ufp_wmask)) begin
          w_accept     = 1'b1;
          w_state_next = TAG;
        end
      end
      TAG: begin
        if (r_rmask == 4'b0 && r_wmask == 4'b0) begin
          w_resp_fire  = 1'b1;
          w_state_next = IDLE;
        end else if (w_hit) begin
          w_resp_fire  = 1'b1;
          w_plru_upd   = 1'b1;
          w_wr_hit     = |r_wmask;
          w_state_next = IDLE;
        end else begin
          w_victim_load = 1'b1;
          w_state_next  = (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) ? WB : ALLOC;
        end
      end
      WB:    if (dfp_resp) w_state_next = ALLOC;
      ALLOC: if (dfp_resp) begin
        w_fill       = 1'b1;
        w_state_next = TAG;
      end
      FSCAN: begin
        w_flush_inval = 1'b1;
        if (r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway]) w_state_next = FWB;
        else if (w_flush_last) begin
          w_flush_finish = 1'b1;
          w_state_next   = IDLE;
        end else w_flush_adv = 1'b1;
      end
      FWB: if (dfp_resp) begin
        if (w_flush_last) begin
          w_flush_finish = 1'b1;
          w_state_next   = IDLE;
        end else begin
          w_flush_adv  = 1'b1;
          w_state_next = FSCAN;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    dfp_read  = (r_state == ALLOC);
    dfp_write = (r_state == WB) || (r_state == FWB);
    dfp_addr  = '0;
    dfp_wdata = '0;
    case (r_state)
      ALLOC: dfp_addr = {r_addr[31:5], 5'b0};
      WB: begin
        dfp_addr  = {r_tag[w_set][r_victim], w_set, 5'b0};
        dfp_wdata = r_data[w_set][r_victim];
      end
      FWB: begin
        dfp_addr  = {r_tag[r_fset][r_fway], r_fset, 5'b0};
        dfp_wdata = r_data[r_fset][r_fway];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      ufp_resp   <= 1'b0;
      ufp_rdata  <= '0;
      flush_done <= 1'b0;
      r_addr     <= '0;
      r_rmask    <= '0;
      r_wmask    <= '0;
      r_wdata    <= '0;
      r_squash   <= 1'b0;
      r_victim   <= '0;
      r_fset     <= '0;
      r_fway     <= '0;
      for (int s = 0; s < NUM_SET; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < NUM_WAY; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      r_state    <= w_state_next;
      ufp_resp   <= w_resp_fire & ~w_squash;
      flush_done <= w_flush_finish;
      if (w_resp_fire && !w_squash && w_hit) ufp_rdata <= w_hit_word;
      if (w_accept) begin
        r_addr   <= ufp_addr[31:2];
        r_rmask  <= ufp_rmask;
        r_wmask  <= (WRITE_EN != 0) ? ufp_wmask : 4'b0;
        r_wdata  <= ufp_wdata;
        r_squash <= squash;
      end else if (r_state != IDLE && squash) begin
        r_squash <= 1'b1;
      end
      if (w_victim_load) r_victim <= w_victim;
      if (w_fill) begin
        r_valid[w_set][r_victim] <= 1'b1;
        r_dirty[w_set][r_victim] <= 1'b0;
      end
      if (w_wr_hit)   r_dirty[w_set][w_hit_way] <= 1'b1;
      if (w_plru_upd) r_plru[w_set] <= plru_touch(r_plru[w_set], w_hit_way);
      if (w_flush_start) begin
        r_fset <= '0;
        r_fway <= '0;
      end
      if (w_flush_inval) begin
        r_valid[r_fset][r_fway] <= 1'b0;
        r_dirty[r_fset][r_fway] <= 1'b0;
      end
      if (w_flush_adv) begin
        if (r_fway == WAY_W'(NUM_WAY - 1)) begin
          r_fway <= '0;
          r_fset <= r_fset + SET_IDX'(1);
        end else begin
          r_fway <= r_fway + WAY_W'(1);
        end
      end
      if (w_flush_finish) begin
        r_fset <= '0;
        r_fway <= '0;
        for (int s = 0; s < NUM_SET; s++) r_plru[s] <= '0;
      end
    end
  end

  // Tag and line storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_set][r_victim] <= dfp_rdata;
      r_tag[w_set][r_victim]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_set][w_hit_way] <= w_merged;
    end
  end
endmodule

// File: tb/tb_gen_cache.sv
// Directed and randomized checks of gen_cache against a byte-level memory image model.
module tb_gen_cache;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  ufp_addr, ufp_wdata, ufp_rdata, dfp_addr;
  logic [3:0]   ufp_rmask, ufp_wmask;
  logic         ufp_resp, dfp_read, dfp_write, dfp_resp, flush_all, flush_done, squash;
  logic [255:0] dfp_rdata, dfp_wdata;

  always #5 clk = ~clk;

  gen_cache #(.NUM_SET(16), .NUM_WAY(4), .WRITE_EN(1)) dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_wmask(ufp_wmask),
    .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_rdata(dfp_rdata), .dfp_wdata(dfp_wdata), .dfp_resp(dfp_resp),
    .flush_all(flush_all), .flush_done(flush_done), .squash(squash)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory plus the architectural image (what a read must return).
  logic [255:0] mem    [bit [26:0]];
  logic [255:0] shadow [bit [26:0]];

  function automatic logic [255:0] default_line(input logic [26:0] l);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = (32'(l) * 32'h0100_0193) ^ (32'h1357_9BDF * 32'(k + 1));
    return v;
  endfunction

  function automatic logic [255:0] mem_get(input logic [26:0] l);
    return mem.exists(l) ? mem[l] : default_line(l);
  endfunction

  function automatic logic [255:0] arch_get(input logic [26:0] l);
    return shadow.exists(l) ? shadow[l] : mem_get(l);
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [255:0] ln;
    ln = arch_get(a[31:5]);
    return ln[int'(a[4:2])*32 +: 32];
  endfunction

  task automatic arch_write(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd);
    logic [255:0] ln;
    ln = arch_get(a[31:5]);
    for (int b = 0; b < 4; b++)
      if (wm[b]) ln[int'(a[4:2])*32 + b*8 +: 8] = wd[b*8 +: 8];
    shadow[a[31:5]] = ln;
  endtask

  // Memory responder with random latency; mem_stall holds requests forever.
  typedef struct packed { logic w; logic [31:0] a; } ev_t;
  ev_t         ev_log[$];
  bit          mem_stall = 1'b0;
  int          rd_cnt = 0, wr_cnt = 0, lat_left = -1;
  logic [31:0] last_rd_addr = '0;

  initial begin
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    forever begin
      @(negedge clk);
      if (dfp_resp) dfp_resp = 1'b0;
      else if (!rst || !(dfp_read || dfp_write)) lat_left = -1;
      else begin
        check_eq("rd_wr_excl", 256'(dfp_read & dfp_write), 256'd0);
        check_eq("dfp_align", 256'(dfp_addr[4:0]), 256'd0);
        if (lat_left < 0) lat_left = int'($urandom_range(0, 3));
        if (!mem_stall) begin
          if (lat_left == 0) begin
            dfp_resp = 1'b1;
            lat_left = -1;
            if (dfp_write) begin
              mem[dfp_addr[31:5]] = dfp_wdata;
              wr_cnt++;
              ev_log.push_back('{1'b1, dfp_addr});
            end else begin
              dfp_rdata    = mem_get(dfp_addr[31:5]);
              rd_cnt++;
              last_rd_addr = dfp_addr;
              ev_log.push_back('{1'b0, dfp_addr});
            end
          end else lat_left--;
        end
      end
    end
  end

  int resp_cnt = 0, fd_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (ufp_resp)   resp_cnt++;
    if (flush_done) fd_cnt++;
  end

  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat, output bit got);
    @(negedge clk);
    ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
    @(negedge clk);
    ufp_rmask = 4'b0; ufp_wmask = 4'b0;
    lat = 1;
    got = 1'b0;
    while (lat < 300) begin
      if (ufp_resp) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    rd = ufp_rdata;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, output int lat);
    logic [31:0] rd;
    bit got;
    do_req(a, 4'hF, 4'h0, 32'h0, rd, lat, got);
    check_eq({tag, "_resp"}, 256'(got), 256'd1);
    check_eq({tag, "_data"}, 256'(rd), 256'(arch_word(a)));
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd);
    logic [31:0] rd;
    int lat;
    bit got;
    arch_write(a, wm, wd);
    do_req(a, 4'h0, wm, wd, rd, lat, got);
    check_eq({tag, "_resp"}, 256'(got), 256'd1);
  endtask

  task automatic do_flush();
    int n;
    @(negedge clk);
    flush_all = 1'b1;
    @(negedge clk);
    flush_all = 1'b0;
    n = 0;
    while (!flush_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("flush_done_seen", 256'(flush_done), 256'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    shadow.delete();
  endtask

  initial begin
    logic [31:0]  a, wd, rd;
    logic [3:0]   wm;
    logic [255:0] ln;
    int lat, r0, w0, c0, f0, n;
    bit got;
    flush_all = 1'b0; squash = 1'b0;
    ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;

    repeat (2) @(negedge clk);
    check_eq("rst_ufp_resp", 256'(ufp_resp), 256'd0);
    check_eq("rst_ufp_rdata", 256'(ufp_rdata), 256'd0);
    check_eq("rst_dfp_read", 256'(dfp_read), 256'd0);
    check_eq("rst_dfp_write", 256'(dfp_write), 256'd0);
    check_eq("rst_dfp_addr", 256'(dfp_addr), 256'd0);
    check_eq("rst_dfp_wdata", dfp_wdata, 256'd0);
    check_eq("rst_flush_done", 256'(flush_done), 256'd0);
    rst = 1'b1;

    // Cold read miss, then a repeat that must hit with no memory traffic.
    ln = default_line(27'h80);
    ln[63:32] = 32'hDEAD_BEEF;
    mem[27'h80] = ln;
    r0 = rd_cnt;
    do_read("cold", 32'h0000_1004, lat);
    check_eq("cold_rd_cnt", 256'(rd_cnt - r0), 256'd1);
    check_eq("cold_rd_addr", 256'(last_rd_addr), 256'h1000);
    check_eq("cold_value", 256'(ufp_rdata), 256'hDEAD_BEEF);
    r0 = rd_cnt; w0 = wr_cnt;
    do_read("rehit", 32'h0000_1004, lat);
    check_eq("rehit_latency", 256'(lat), 256'd2);
    check_eq("rehit_dfp_idle", 256'((rd_cnt - r0) + (wr_cnt - w0)), 256'd0);

    do_write("bytewr", 32'h0000_1004, 4'b0010, 32'h0000_AB00);
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, rd, lat, got);
    check_eq("bytewr_value", 256'(rd), 256'hDEAD_ABEF);

    // Dirty eviction in set 0: writeback of 0x0 precedes the fill of 0x800.
    do_reset();
    do_write("ev_w0", 32'h0000_0000, 4'hF, 32'hCAFE_F00D);
    do_read("ev_r200", 32'h0000_0200, lat);
    do_read("ev_r400", 32'h0000_0400, lat);
    do_read("ev_r600", 32'h0000_0600, lat);
    ev_log.delete();
    do_read("ev_r800", 32'h0000_0800, lat);
    check_eq("ev_count", 256'(ev_log.size()), 256'd2);
    check_eq("ev0_is_write", 256'(ev_log[0].w), 256'd1);
    check_eq("ev0_addr", 256'(ev_log[0].a), 256'h0);
    check_eq("ev1_is_read", 256'(ev_log[1].w), 256'd0);
    check_eq("ev1_addr", 256'(ev_log[1].a), 256'h800);
    check_eq("ev_wb_data", mem_get(27'h0), arch_get(27'h0));

    // Flush with exactly two dirty lines.
    do_write("fl_w200", 32'h0000_0204, 4'b1001, 32'h1122_3344);
    do_write("fl_w400", 32'h0000_0408, 4'hF, 32'h5566_7788);
    w0 = wr_cnt; f0 = fd_cnt; c0 = resp_cnt;
    do_flush();
    check_eq("flush_writes", 256'(wr_cnt - w0), 256'd2);
    check_eq("flush_done_pulses", 256'(fd_cnt - f0), 256'd1);
    check_eq("flush_no_resp", 256'(resp_cnt - c0), 256'd0);
    r0 = rd_cnt;
    do_read("post_fl_200", 32'h0000_0204, lat);
    check_eq("post_fl_200_miss", 256'(rd_cnt - r0), 256'd1);
    r0 = rd_cnt;
    do_read("post_fl_400", 32'h0000_0408, lat);
    check_eq("post_fl_400_miss", 256'(rd_cnt - r0), 256'd1);

    // Reset while a fill is outstanding.
    mem_stall = 1'b1;
    @(negedge clk);
    ufp_addr = 32'h0000_0A00; ufp_rmask = 4'hF;
    @(negedge clk);
    ufp_rmask = 4'h0;
    n = 0;
    while (!dfp_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("alloc_reached", 256'(dfp_read), 256'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_drops_read", 256'(dfp_read), 256'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_stall = 1'b0;
    shadow.delete();
    r0 = rd_cnt;
    do_read("post_rst", 32'h0000_0A00, lat);
    check_eq("post_rst_miss", 256'(rd_cnt - r0), 256'd1);

    // Squashed read miss: no response, but the fill completes.
    c0 = resp_cnt;
    @(negedge clk);
    ufp_addr = 32'h0000_0C08; ufp_rmask = 4'hF;
    @(negedge clk);
    ufp_rmask = 4'h0; squash = 1'b1;
    @(negedge clk);
    squash = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("squash_no_resp", 256'(resp_cnt - c0), 256'd0);
    r0 = rd_cnt;
    do_read("post_squash", 32'h0000_0C08, lat);
    check_eq("post_squash_lat", 256'(lat), 256'd2);
    check_eq("post_squash_hit", 256'(rd_cnt - r0), 256'd0);

    // Random traffic over three sets with eight tags each to force evictions.
    for (int i = 0; i < 400; i++) begin
      a = {$urandom_range(0, 7), 9'b0} | {$urandom_range(0, 2) == 0 ? 4'd0 :
           ($urandom_range(0, 1) == 0 ? 4'd1 : 4'd5), 5'b0} | {$urandom_range(0, 7), 2'b0};
      if ($urandom_range(0, 99) < 3) begin
        c0 = resp_cnt;
        do_flush();
        check_eq("rnd_flush_no_resp", 256'(resp_cnt - c0), 256'd0);
      end else if ($urandom_range(0, 1) == 0) begin
        wm = 4'($urandom_range(1, 15));
        wd = $urandom;
        do_write("rnd_wr", a, wm, wd);
      end else begin
        r0 = rd_cnt;
        do_read("rnd_rd", a, lat);
        if (rd_cnt != r0) check_eq("rnd_fill_addr", 256'(last_rd_addr), 256'({a[31:5], 5'b0}));
        else check_eq("rnd_hit_lat", 256'(lat), 256'd2);
      end
    end
    do_flush();
    for (int t = 0; t < 8; t++) begin
      for (int s = 0; s < 16; s++) begin
        if (s == 0 || s == 1 || s == 5)
          check_eq("final_image", mem_get(27'((t << 4) | s)), arch_get(27'((t << 4) | s)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
